// File: rtl/rls_arith_pkg.sv
// Shared arithmetic constants and helpers for the RLS datapath blocks:
// operand width bounds, pipeline depth bounds and saturation limits.
package rls_arith_pkg;

    localparam int RLS_MAX_W  = 64;
    localparam int RLS_MIN_W  = 8;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    typedef enum logic {
        OP_SUB = 1'b0,
        OP_ADD = 1'b1
    } op_e;

    // Limits are returned at the widest supported width; callers keep the low w bits.
    function automatic logic [RLS_MAX_W-1:0] sat_max_lim(input int w);
        sat_max_lim = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [RLS_MAX_W-1:0] sat_min_lim(input int w);
        sat_min_lim = ~sat_max_lim(w);
    endfunction

    function automatic int clamp_stages(input int s);
        if (s < STAGES_MIN)      clamp_stages = STAGES_MIN;
        else if (s > STAGES_MAX) clamp_stages = STAGES_MAX;
        else                     clamp_stages = s;
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational add/subtract at nBits+1 bits with overflow detection and
// optional clamp to the signed nBits range.
module sat_add
    import rls_arith_pkg::*;
#(
    parameter int nBits = 32,
    parameter int SAT   = 1
) (
    input  logic signed [nBits-1:0] x_i,
    input  logic signed [nBits-1:0] y_i,
    input  logic                    sum_i,
    output logic signed [nBits-1:0] res_o,
    output logic                    ovf_o
);

    localparam logic [RLS_MAX_W-1:0] MAX_W = sat_max_lim(nBits);
    localparam logic [RLS_MAX_W-1:0] MIN_W = sat_min_lim(nBits);
    localparam logic signed [nBits-1:0] MAX_V = MAX_W[nBits-1:0];
    localparam logic signed [nBits-1:0] MIN_V = MIN_W[nBits-1:0];

    logic signed [nBits:0] xe;
    logic signed [nBits:0] ye;
    logic signed [nBits:0] se;
    logic                  ovf;

    always_comb begin
        xe = {x_i[nBits-1], x_i};
        ye = {y_i[nBits-1], y_i};
        se = (op_e'(sum_i) == OP_ADD) ? (xe + ye) : (xe - ye);
        ovf = se[nBits] ^ se[nBits-1];
        res_o = se[nBits-1:0];
        // The extra top bit carries the true sign and picks the clamp direction.
        if ((SAT != 0) && ovf) begin
            res_o = se[nBits] ? MIN_V : MAX_V;
        end
        ovf_o = ovf;
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined saturating add/subtract with an internal accumulator. Stage 1
// computes; the remaining stages only carry result, overflow and valid.
module addsub_pipe
    import rls_arith_pkg::*;
#(
    parameter int nBits  = 32,
    parameter int STAGES = 2,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sum,
    input  logic                    acc_mode,
    input  logic                    acc_clr,
    input  logic signed [nBits-1:0] a,
    input  logic signed [nBits-1:0] b,
    output logic signed [nBits-1:0] res,
    output logic                    ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int DEPTH = clamp_stages(STAGES);

    logic                    advance;
    logic                    accept;
    logic signed [nBits-1:0] acc_q;
    logic signed [nBits-1:0] acc_d;
    logic signed [nBits-1:0] acc_prev;
    logic signed [nBits-1:0] op_x;
    logic signed [nBits-1:0] op_y;
    logic signed [nBits-1:0] s1_res;
    logic                    s1_ovf;

    logic signed [nBits-1:0] res_q [DEPTH];
    logic                    ovf_q [DEPTH];
    logic                    vld_q [DEPTH];

    // A full output that is not being drained stalls the whole pipe.
    assign advance  = enable & (~out_valid | out_ready);
    assign in_ready = advance & rst_n;
    assign accept   = in_valid & in_ready;

    always_comb begin
        acc_prev = acc_clr ? '0 : acc_q;
        op_x     = acc_mode ? acc_prev : a;
        op_y     = acc_mode ? a : b;
    end

    sat_add #(
        .nBits (nBits),
        .SAT   (SAT)
    ) u_sat_add (
        .x_i   (op_x),
        .y_i   (op_y),
        .sum_i (sum),
        .res_o (s1_res),
        .ovf_o (s1_ovf)
    );

    // Accumulator takes the clamped result on the accepting cycle, so the
    // next accumulate beat sees it without any forwarding.
    always_comb begin
        acc_d = acc_q;
        if (enable && acc_clr) begin
            acc_d = '0;
        end
        if (accept && acc_mode) begin
            acc_d = s1_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                res_q[i] <= '0;
                ovf_q[i] <= 1'b0;
            end
        end else if (advance) begin
            vld_q[0] <= accept;
            res_q[0] <= s1_res;
            ovf_q[0] <= s1_ovf;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
            end
        end
    end

    assign res       = res_q[DEPTH-1];
    assign ovf       = ovf_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];

endmodule
